// File: rtl/sample_sequencer_pkg.sv
// Shared types and defaults for the per-sample echo-cancellation sequencer.
// The FSM state type is also exported through the interface as a debug view.
package sample_seq_pkg;

  localparam int DEF_PULSE_LEN    = 2;
  localparam int DEF_CONV_TIMEOUT = 25;
  localparam int DEF_LAG_TIMEOUT  = 130;
  localparam int DEF_CANCEL_DELAY = 2;
  localparam int DEF_CNT_W        = 13;
  localparam int STAT_W           = 16;
  localparam int TMR_W            = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CONV_EN   = 3'd1,
    S_CONV_WAIT = 3'd2,
    S_LAG_EN    = 3'd3,
    S_LAG_WAIT  = 3'd4,
    S_OUT_HOLD  = 3'd5
  } seq_state_t;

  // A timeout and an overrun can land on the same edge, so up to 2 drops at once.
  function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                input logic [1:0] b);
    logic [STAT_W:0] s;
    s = {1'b0, a} + {{(STAT_W-1){1'b0}}, b};
    return s[STAT_W] ? {STAT_W{1'b1}} : s[STAT_W-1:0];
  endfunction

endpackage

// File: rtl/sample_sequencer_if.sv
// Handshake bundle between the sequencer (master) and the processing stages (slave).
// enable_* are initiator strobes/levels; ready_* are honoured only while the sequencer waits for them.
interface sample_sequencer_if import sample_seq_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W
) ();

  logic [CNT_W-1:0]  sampling_cycle_counter;
  logic              ready_conv;
  logic              ready_lag;
  logic              enable_conv;
  logic              enable_lag;
  logic              enable_out;
  logic              enable_cancel;
  logic              busy;
  logic [STAT_W-1:0] frame_count;
  logic [STAT_W-1:0] drop_count;
  logic              err_conv_to;
  logic              err_lag_to;
  logic              err_overrun;
  seq_state_t        dbg_state;

  modport master (
    input  sampling_cycle_counter, ready_conv, ready_lag,
    output enable_conv, enable_lag, enable_out, enable_cancel, busy,
           frame_count, drop_count, err_conv_to, err_lag_to, err_overrun, dbg_state
  );

  modport slave (
    output sampling_cycle_counter, ready_conv, ready_lag,
    input  enable_conv, enable_lag, enable_out, enable_cancel, busy,
           frame_count, drop_count, err_conv_to, err_lag_to, err_overrun, dbg_state
  );

endinterface

// File: rtl/sample_sequencer_timer.sv
// Loadable up/down counter shared by the pulse, timeout and hold phases.
// o_done flags a zero count, used to end down-counted pulse and hold phases.
module seq_timer import sample_seq_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [TMR_W-1:0] i_load_val,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [TMR_W-1:0] o_count,
  output logic             o_done
);

  logic [TMR_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_count <= '0;
    else if (i_load) r_count <= i_load_val;
    else if (i_inc)  r_count <= r_count + TMR_W'(1);
    else if (i_dec)  r_count <= r_count - TMR_W'(1);
  end

  assign o_count = r_count;
  assign o_done  = (r_count == '0);

endmodule

// File: rtl/sample_sequencer.sv
// Per-sample initiator for the converter -> lag -> output/cancel chain.
// Starts a frame on counter==0, pulses stage enables and waits for each ready with a timeout.
module sample_sequencer import sample_seq_pkg::*; #(
  parameter int PULSE_LEN    = DEF_PULSE_LEN,
  parameter int CONV_TIMEOUT = DEF_CONV_TIMEOUT,
  parameter int LAG_TIMEOUT  = DEF_LAG_TIMEOUT,
  parameter int CANCEL_DELAY = DEF_CANCEL_DELAY,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic                clk_operation,
  input  logic                rst,
  sample_sequencer_if.master  bus
);

  seq_state_t        r_state;
  logic              r_enable_conv, r_enable_lag, r_enable_out, r_enable_cancel, r_busy;
  logic              r_err_conv_to, r_err_lag_to, r_err_overrun;
  logic [STAT_W-1:0] r_frame_count, r_drop_count;

  logic             w_start, w_overrun, w_conv_to, w_lag_to;
  logic [1:0]       w_drop_inc;
  logic             w_tmr_load, w_tmr_inc, w_tmr_dec, w_tmr_done;
  logic [TMR_W-1:0] w_tmr_val, w_tmr_count;

  assign w_start    = (bus.sampling_cycle_counter == {CNT_W{1'b0}});
  assign w_overrun  = w_start && (r_state != S_IDLE);
  assign w_conv_to  = (r_state == S_CONV_WAIT) && !bus.ready_conv &&
                      (w_tmr_count == TMR_W'(CONV_TIMEOUT - 1));
  assign w_lag_to   = (r_state == S_LAG_WAIT) && !bus.ready_lag &&
                      (w_tmr_count == TMR_W'(LAG_TIMEOUT - 1));
  assign w_drop_inc = {1'b0, w_overrun} + {1'b0, (w_conv_to | w_lag_to)};

  // IDLE keeps the timer preloaded so the first pulse cycle needs no extra setup edge.
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    w_tmr_inc  = 1'b0;
    w_tmr_dec  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tmr_load = 1'b1;
        w_tmr_val  = TMR_W'(PULSE_LEN - 1);
      end
      S_CONV_EN, S_LAG_EN: begin
        if (w_tmr_done) w_tmr_load = 1'b1;
        else            w_tmr_dec  = 1'b1;
      end
      S_CONV_WAIT: begin
        if (bus.ready_conv) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = TMR_W'(PULSE_LEN - 1);
        end else begin
          w_tmr_inc = 1'b1;
        end
      end
      S_LAG_WAIT: begin
        if (bus.ready_lag) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = TMR_W'(CANCEL_DELAY - 1);
        end else begin
          w_tmr_inc = 1'b1;
        end
      end
      S_OUT_HOLD: w_tmr_dec = 1'b1;
      default:    w_tmr_load = 1'b1;
    endcase
  end

  seq_timer u_timer (
    .clk        (clk_operation),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_inc      (w_tmr_inc),
    .i_dec      (w_tmr_dec),
    .o_count    (w_tmr_count),
    .o_done     (w_tmr_done)
  );

  always_ff @(posedge clk_operation or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_enable_conv   <= 1'b0;
      r_enable_lag    <= 1'b0;
      r_enable_out    <= 1'b0;
      r_enable_cancel <= 1'b0;
      r_busy          <= 1'b0;
      r_err_conv_to   <= 1'b0;
      r_err_lag_to    <= 1'b0;
      r_err_overrun   <= 1'b0;
      r_frame_count   <= '0;
      r_drop_count    <= '0;
    end else begin
      r_drop_count <= sat_add(r_drop_count, w_drop_inc);
      if (w_overrun) r_err_overrun <= 1'b1;
      case (r_state)
        S_IDLE: if (w_start) begin
          r_state       <= S_CONV_EN;
          r_enable_conv <= 1'b1;
          r_busy        <= 1'b1;
        end
        S_CONV_EN: if (w_tmr_done) begin
          r_state       <= S_CONV_WAIT;
          r_enable_conv <= 1'b0;
        end
        S_CONV_WAIT: if (bus.ready_conv) begin
          r_state      <= S_LAG_EN;
          r_enable_lag <= 1'b1;
        end else if (w_conv_to) begin
          r_state       <= S_IDLE;
          r_err_conv_to <= 1'b1;
          r_busy        <= 1'b0;
        end
        S_LAG_EN: if (w_tmr_done) begin
          r_state      <= S_LAG_WAIT;
          r_enable_lag <= 1'b0;
        end
        S_LAG_WAIT: if (bus.ready_lag) begin
          r_state      <= S_OUT_HOLD;
          r_enable_out <= 1'b1;
        end else if (w_lag_to) begin
          r_state      <= S_IDLE;
          r_err_lag_to <= 1'b1;
          r_busy       <= 1'b0;
        end
        S_OUT_HOLD: if (w_tmr_done) begin
          r_state         <= S_IDLE;
          r_enable_cancel <= 1'b1;
          r_frame_count   <= r_frame_count + STAT_W'(1);
          r_busy          <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.enable_conv   = r_enable_conv;
  assign bus.enable_lag    = r_enable_lag;
  assign bus.enable_out    = r_enable_out;
  assign bus.enable_cancel = r_enable_cancel;
  assign bus.busy          = r_busy;
  assign bus.frame_count   = r_frame_count;
  assign bus.drop_count    = r_drop_count;
  assign bus.err_conv_to   = r_err_conv_to;
  assign bus.err_lag_to    = r_err_lag_to;
  assign bus.err_overrun   = r_err_overrun;
  assign bus.dbg_state     = r_state;

endmodule

// File: tb/tb_sample_sequencer.sv
// Bench for sample_sequencer: a timeline model (frame start / ready edges -> output windows)
// checked every cycle, plus hand-computed literal expectations for the directed scenarios.
module tb_sample_sequencer;
  import sample_seq_pkg::*;

  localparam int P   = 2;
  localparam int CT  = 25;
  localparam int LT  = 130;
  localparam int D   = 2;
  localparam int CW  = 13;
  localparam int PER = 200;
  localparam int NFR = 70;

  logic clk_operation = 1'b0;
  logic rst = 1'b0;

  sample_sequencer_if #(.CNT_W(CW)) bus ();

  sample_sequencer #(
    .PULSE_LEN(P), .CONV_TIMEOUT(CT), .LAG_TIMEOUT(LT), .CANCEL_DELAY(D), .CNT_W(CW)
  ) dut (
    .clk_operation (clk_operation),
    .rst           (rst),
    .bus           (bus)
  );

  // clock / reset
  always #5 clk_operation = ~clk_operation;

  int n_vec = 0;
  int n_miss = 0;
  int rel = 0;

  // Timeline model: a frame is described by its start edge t, converter-ready edge u and
  // lag-ready edge v; output windows follow directly from those edges.
  int   m_n, m_t, m_u, m_v, m_frames, m_drops;
  logic m_active, m_out, m_cancel, m_cto, m_lto, m_ovr;

  always @(posedge clk_operation or posedge rst) begin
    if (rst) begin
      m_n = 0; m_t = -1000; m_u = -1000; m_v = -1000; m_frames = 0; m_drops = 0;
      m_active = 1'b0; m_out = 1'b0; m_cancel = 1'b0;
      m_cto = 1'b0; m_lto = 1'b0; m_ovr = 1'b0;
    end else begin
      m_n++;
      if (m_active) begin
        if (bus.sampling_cycle_counter == '0) begin
          m_ovr = 1'b1;
          m_drops++;
        end
        if (m_u < 0) begin
          if (m_n >= m_t + P + 1 && bus.ready_conv) m_u = m_n;
          else if (m_n == m_t + P + CT) begin
            m_cto = 1'b1; m_drops++; m_active = 1'b0;
          end
        end else if (m_v < 0) begin
          if (m_n >= m_u + P + 1 && bus.ready_lag) begin
            m_v = m_n; m_out = 1'b1;
          end else if (m_n == m_u + P + LT) begin
            m_lto = 1'b1; m_drops++; m_active = 1'b0;
          end
        end else if (m_n == m_v + D) begin
          m_cancel = 1'b1; m_frames++; m_active = 1'b0;
        end
      end else if (bus.sampling_cycle_counter == '0) begin
        m_active = 1'b1; m_t = m_n; m_u = -1000; m_v = -1000;
      end
    end
  end

  function automatic logic [39:0] dut_vec();
    return {bus.enable_conv, bus.enable_lag, bus.enable_out, bus.enable_cancel, bus.busy,
            bus.err_conv_to, bus.err_lag_to, bus.err_overrun, bus.frame_count, bus.drop_count};
  endfunction

  function automatic logic [39:0] model_vec();
    logic e_conv, e_lag;
    logic [15:0] e_fr, e_dr;
    e_conv = (m_n >= m_t) && (m_n <= m_t + P - 1);
    e_lag  = (m_n >= m_u) && (m_n <= m_u + P - 1);
    e_fr   = m_frames[15:0];
    e_dr   = (m_drops > 65535) ? 16'hFFFF : m_drops[15:0];
    return {e_conv, e_lag, m_out, m_cancel, m_active, m_cto, m_lto, m_ovr, e_fr, e_dr};
  endfunction

  // scoreboard: literal check and per-cycle model compare
  task automatic lit(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (rel edge %0d)", name, act, exp, rel);
    end
  endtask

  task automatic tick();
    @(negedge clk_operation);
    lit("model_cmp", dut_vec(), model_vec());
  endtask

  // driver tasks
  task automatic drive_edge(input logic zero, input logic rc, input logic rl);
    bus.sampling_cycle_counter = zero ? CW'(0) : CW'(1);
    bus.ready_conv = rc;
    bus.ready_lag  = rl;
    tick();
    rel++;
  endtask

  task automatic do_reset();
    bus.sampling_cycle_counter = CW'(1);
    bus.ready_conv = 1'b0;
    bus.ready_lag  = 1'b0;
    #2 rst = 1'b1;
    tick();
    tick();
    #2 rst = 1'b0;
    tick();
    rel = 0;
  endtask

  task automatic run_nominal(input string tag);
    for (int k = 1; k <= 70; k++) begin
      drive_edge(k == 10, k == 20, k == 60);
      case (k)
        9:  lit({tag, "_conv_before"}, bus.enable_conv, 0);
        10: lit({tag, "_conv_c11"}, bus.enable_conv, 1);
        11: lit({tag, "_conv_c12"}, bus.enable_conv, 1);
        12: lit({tag, "_conv_c13"}, bus.enable_conv, 0);
        20: lit({tag, "_lag_c21"}, bus.enable_lag, 1);
        21: lit({tag, "_lag_c22"}, bus.enable_lag, 1);
        22: lit({tag, "_lag_c23"}, bus.enable_lag, 0);
        59: lit({tag, "_out_c60"}, bus.enable_out, 0);
        60: lit({tag, "_out_c61"}, bus.enable_out, 1);
        61: lit({tag, "_cancel_c62"}, bus.enable_cancel, 0);
        62: begin
          lit({tag, "_cancel_c63"}, bus.enable_cancel, 1);
          lit({tag, "_frames"}, bus.frame_count, 1);
        end
        default: ;
      endcase
    end
  endtask

  int run, pulses, ph, f, rc, rl;
  logic lag_seen;

  initial begin
    bus.sampling_cycle_counter = CW'(1);
    bus.ready_conv = 1'b0;
    bus.ready_lag  = 1'b0;

    do_reset();
    lit("reset_outputs", dut_vec(), 40'd0);

    run_nominal("nom");

    // converter timeout: no ready_conv
    do_reset();
    lag_seen = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      drive_edge(k == 10, 1'b0, 1'b0);
      lag_seen |= bus.enable_lag;
      if (k == 36) lit("cto_not_yet", bus.err_conv_to, 0);
      if (k == 37) begin
        lit("cto_flag", bus.err_conv_to, 1);
        lit("cto_busy", bus.busy, 0);
        lit("cto_drops", bus.drop_count, 1);
      end
    end
    lit("cto_no_lag", lag_seen, 0);

    // lag timeout: ready_conv at 15, no ready_lag
    do_reset();
    for (int k = 1; k <= 160; k++) begin
      drive_edge(k == 10, k == 15, 1'b0);
      if (k == 146) lit("lto_not_yet", bus.err_lag_to, 0);
      if (k == 147) begin
        lit("lto_flag", bus.err_lag_to, 1);
        lit("lto_busy", bus.busy, 0);
      end
    end
    lit("lto_out", bus.enable_out, 0);
    lit("lto_frames", bus.frame_count, 0);
    lit("lto_drops", bus.drop_count, 1);

    // overrun 40 cycles into the frame
    do_reset();
    for (int k = 1; k <= 80; k++) begin
      drive_edge(k == 10 || k == 50, k == 20, k == 60);
      if (k == 49) lit("ovr_not_yet", bus.err_overrun, 0);
      if (k == 50) begin
        lit("ovr_flag", bus.err_overrun, 1);
        lit("ovr_drops", bus.drop_count, 1);
        lit("ovr_no_conv", bus.enable_conv, 0);
      end
      if (k == 62) lit("ovr_frames", bus.frame_count, 1);
    end

    // counter==0 on the edge that returns to IDLE is an overrun, next 0 starts
    do_reset();
    for (int k = 1; k <= 95; k++) begin
      drive_edge(k == 10 || k == 62 || k == 80, k == 20 || k == 90, k == 60);
      if (k == 62) begin
        lit("edge_ovr_flag", bus.err_overrun, 1);
        lit("edge_ovr_busy", bus.busy, 0);
      end
      if (k == 63) lit("edge_ovr_no_conv", bus.enable_conv, 0);
      if (k == 80) lit("edge_ovr_restart", bus.enable_conv, 1);
      if (k == 90) lit("edge_ovr_lag", bus.enable_lag, 1);
    end

    // reset during cycle 12 of a nominal frame
    do_reset();
    for (int k = 1; k <= 11; k++) drive_edge(k == 10, 1'b0, 1'b0);
    lit("rst_pulse_live", bus.enable_conv, 1);
    #2 rst = 1'b1;
    #1 lit("rst_async_clear", dut_vec(), 40'd0);
    tick();
    #2 rst = 1'b0;
    tick();
    rel = 0;
    run_nominal("post_rst");

    // back-to-back frames with a free-running counter
    do_reset();
    run = 0;
    pulses = 0;
    for (int c = PER - 5; c < (NFR + 1) * PER; c++) begin
      ph = c % PER;
      f  = c / PER;
      rc = 3 + f % 25;
      rl = rc + 3 + (f * 7) % 100;
      bus.sampling_cycle_counter = CW'(ph);
      bus.ready_conv = (ph == rc) || (ph == rc + 1);
      bus.ready_lag  = (ph >= rl) && (ph <= rl + 2);
      tick();
      if (bus.enable_conv) run++;
      else if (run != 0) begin
        lit("b2b_pulse_width", run, 2);
        pulses++;
        run = 0;
      end
    end
    lit("b2b_frames", bus.frame_count, NFR);
    lit("b2b_pulses", pulses, NFR);
    lit("b2b_errors", {bus.err_conv_to, bus.err_lag_to, bus.err_overrun}, 0);
    lit("b2b_drops", bus.drop_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
